demux4_pipe: RTL
================

// Module: demux4_pipe
// PURPOSE
//  1-to-4 routing stage, the distribution counterpart of the 4:1 select mux in the datapath.
//  Accepts one W-bit word per cycle on a valid/ready input.
//  Steers each word to one of four output channels by a 2-bit select.
//  Each channel has a single registered holding slot.
//  Sits between the decode/issue logic and four consumers (e.g. reg-file write port, ALU A/B, mem-data).
// PARAMETERS
//  W      8   data width, bits
//  CNT_W  8   width of per-channel accepted-transfer counters
// PORTS
//  Clk        in   1        system clock, all state on rising edge
//  Reset_n    in   1        asynchronous, active-low reset
//  in_valid   in   1        input word present
//  in_ready   out  1        input can be accepted this cycle
//  in_sel     in   2        destination channel 0..3
//  in_data    in   W        input word
//  out_valid  out  4        bit k: channel k slot holds a word
//  out_ready  in   4        bit k: consumer k takes word this cycle
//  out_data   out  4*W      channel k data at [k*W +: W]
//  xfer_cnt   out  4*CNT_W  channel k accepted count at [k*CNT_W +: CNT_W]
//  busy       out  1        OR of out_valid
// BEHAVIOUR
//  Reset and clocking:
//  - One clock, Clk. Reset_n is asynchronous and active-low.
//  - While Reset_n=0: out_valid=0, out_data=0, xfer_cnt=0, busy=0, in_ready=0.
//  - Releasing reset takes effect on the next Clk edge.
//  Per-channel slot k:
//  - 2-state FSM, EMPTY/FULL; FULL iff out_valid[k].
//  - drain_k = out_valid[k] & out_ready[k].
//  - load_k = in_valid & in_ready & (in_sel==k).
//  - EMPTY + load_k -> FULL; out_data[k] <= in_data.
//  - FULL + drain_k & ~load_k -> EMPTY; out_data[k] holds its last value.
//  - FULL + drain_k & load_k -> stays FULL; new word captured. Full throughput, no bubble.
//  - FULL + ~drain_k -> stays FULL; out_data[k] stable. AXI-style hold rule.
//  Input handshake:
//  - in_ready = Reset_n & (~out_valid[in_sel] | out_ready[in_sel]).
//  - in_ready is combinational from out_ready; the path is accepted.
//  - A word is accepted only when in_valid & in_ready. No drop, no duplication.
//  - A stalled channel blocks only words addressed to it (head-of-line at the input).
//  Latency and ordering:
//  - Accepted at edge N -> out_valid[sel]=1 after edge N.
//  - Words to the same channel leave in arrival order. No ordering guarantee across channels.
//  - Consumers may drain all four channels in the same cycle, independently.
//  Counters:
//  - xfer_cnt[k] increments by 1 on each load_k.
//  - Wraps modulo 2^CNT_W: 2^CNT_W-1 -> 0.
//  Reset mid-operation:
//  - Asserting Reset_n=0 while slots are FULL discards their words immediately and asynchronously.
//  - No handshake is completed.
// STRUCTURE
//  - demux_pkg: localparam NUM_CH=4; typedef logic [1:0] ch_sel_t; typedef enum logic {EMPTY, FULL} slot_st_t.
//  - Sub-module demux_slot #(W, CNT_W): one FSM, data reg and counter; exposes can_accept.
//  - Top instantiates 4 demux_slot via generate and muxes can_accept by in_sel.
// TESTING
//  1. Reset: hold Reset_n=0, drive in_valid=1 -> in_ready=0, out_valid=4'b0000, xfer_cnt all 0.
//  2. Single route: sel=2, data=8'hA5, out_ready=4'hF -> next cycle out_valid=4'b0100, out_data[2]=A5, xfer_cnt[2]=1.
//  3. Back-pressure: out_ready[1]=0, send 8'h11 then 8'h22 to ch1.
//     -> second word sees in_ready=0; out_data[1] stays 11 until out_ready[1]=1, then 22 follows.
//  4. Simultaneous load+drain: ch0 FULL with 33, out_ready[0]=1, send 44 to ch0
//     -> in_ready=1, out_valid[0] stays 1, out_data[0]=44, no bubble.
//  5. Isolation: ch3 stalled and FULL, stream sel=0,1,2 each cycle
//     -> all accepted at 1/cycle, ch3 unchanged.
//  6. Wrap and reset: CNT_W=8, 256 loads to ch1 -> xfer_cnt[1]=0.
//     Assert Reset_n mid-burst -> all outputs 0 without waiting for Clk.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and constants for the 1-to-4 routing stage
package demux_pkg;
  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_st_t;
endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one output channel: single holding slot, data register and transfer counter
module demux_slot
  import demux_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             i_load,
  input  logic [W-1:0]     i_data,
  input  logic             i_out_ready,
  output logic             o_can_accept,
  output logic             o_out_valid,
  output logic [W-1:0]     o_out_data,
  output logic [CNT_W-1:0] o_xfer_cnt
);

  slot_st_t         r_state;
  slot_st_t         w_next_state;
  logic [W-1:0]     r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             w_drain;

  assign w_drain = (r_state == FULL) & i_out_ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A drain and a load in the same cycle keeps the slot FULL with the new word.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      EMPTY: if (i_load) w_next_state = FULL;
      FULL:  if (w_drain && !i_load) w_next_state = EMPTY;
      default: w_next_state = EMPTY;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_data <= i_data;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign o_can_accept = (r_state == EMPTY) | i_out_ready;
  assign o_out_valid  = (r_state == FULL);
  assign o_out_data   = r_data;
  assign o_xfer_cnt   = r_cnt;

endmodule

// File: rtl/demux4_pipe.sv
// rtl/demux4_pipe.sv - steers one valid/ready input word per cycle to one of four registered channels
module demux4_pipe
  import demux_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  ch_sel_t                 in_sel,
  input  logic [W-1:0]            in_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*W-1:0]     out_data,
  output logic [NUM_CH*CNT_W-1:0] xfer_cnt,
  output logic                    busy
);

  logic [NUM_CH-1:0] w_can_accept;
  logic [NUM_CH-1:0] w_load;

  // Only the addressed channel can stall the input; others keep flowing.
  assign in_ready = Reset_n & w_can_accept[in_sel];
  assign busy     = |out_valid;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    assign w_load[k] = in_valid & in_ready & (in_sel == ch_sel_t'(k));

    demux_slot #(
      .W     (W),
      .CNT_W (CNT_W)
    ) u_slot (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .i_load       (w_load[k]),
      .i_data       (in_data),
      .i_out_ready  (out_ready[k]),
      .o_can_accept (w_can_accept[k]),
      .o_out_valid  (out_valid[k]),
      .o_out_data   (out_data[k*W +: W]),
      .o_xfer_cnt   (xfer_cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule
